// File: rtl/fifo_drain_ctrl_if.sv
// Signal bundle linking the drain sequencer to the byte FIFO read port and to
// the downstream valid/ready consumer.
interface fifo_drain_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_write;
    logic                  fifo_read;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        input  fifo_write,
        input  out_ready,
        output fifo_read,
        output out_data,
        output out_valid
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        output fifo_write,
        output out_ready,
        input  fifo_read,
        input  out_data,
        input  out_valid
    );
endinterface

// File: rtl/fifo_drain_ctrl.sv
// Read-side sequencer for the block-RAM byte FIFO: pops one entry at a time,
// waits out the FIFO update latency, and presents each byte on a valid/ready slot.
module fifo_drain_ctrl #(
    parameter int DATA_WIDTH    = 8,
    parameter int SETTLE_CYCLES = 3,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    fifo_drain_ctrl_if.master      bus,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] pop_count
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_COOL    = 2'd2
    } state_t;

    localparam logic [3:0]             COOL_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE   = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                  state_r;
    state_t                  state_next_s;
    logic [3:0]              cool_cnt_r;
    logic [DATA_WIDTH-1:0]   out_data_r;
    logic                    out_valid_r;
    logic [COUNT_WIDTH-1:0]  pop_count_r;
    logic                    fifo_read_s;
    logic                    slot_free_s;

    // A new pop may start once the slot is empty, is being drained, or is being flushed.
    assign slot_free_s = !out_valid_r | bus.out_ready | flush;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decision
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!bus.fifo_empty && slot_free_s) begin
                    state_next_s = ST_CAPTURE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                // A producer write wins the FIFO port; retry the pop next cycle.
                if (bus.fifo_write) begin
                    state_next_s = ST_CAPTURE;
                end else begin
                    state_next_s = ST_COOL;
                end
            end
            ST_COOL: begin
                if (cool_cnt_r == 4'd0) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_COOL;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM outputs: the pop strobe
    always_comb begin
        fifo_read_s = 1'b0;
        case (state_r)
            ST_CAPTURE: begin
                if (!reset && !bus.fifo_write) begin
                    fifo_read_s = 1'b1;
                end else begin
                    fifo_read_s = 1'b0;
                end
            end
            default: fifo_read_s = 1'b0;
        endcase
    end

    // Settle countdown after each accepted pop
    always_ff @(posedge clk) begin
        if (reset) begin
            cool_cnt_r <= 4'd0;
        end else if (fifo_read_s) begin
            cool_cnt_r <= COOL_LOAD;
        end else if ((state_r == ST_COOL) && (cool_cnt_r != 4'd0)) begin
            cool_cnt_r <= cool_cnt_r - 4'd1;
        end else begin
            cool_cnt_r <= cool_cnt_r;
        end
    end

    // Output slot: a capture load beats both the consumer handshake and flush clearing
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_WIDTH{1'b0}};
        end else if (fifo_read_s) begin
            out_valid_r <= !flush;
            if (!flush) begin
                out_data_r <= bus.fifo_data;
            end
        end else if (flush || (out_valid_r && bus.out_ready)) begin
            out_valid_r <= 1'b0;
        end
    end

    // Accepted-pop counter, flushed pops included
    always_ff @(posedge clk) begin
        if (reset) begin
            pop_count_r <= {COUNT_WIDTH{1'b0}};
        end else if (fifo_read_s) begin
            pop_count_r <= pop_count_r + CNT_ONE;
        end else begin
            pop_count_r <= pop_count_r;
        end
    end

    assign bus.fifo_read = fifo_read_s;
    assign bus.out_data  = out_data_r;
    assign bus.out_valid = out_valid_r;
    assign busy          = (state_r != ST_IDLE) | out_valid_r;
    assign pop_count     = pop_count_r;
endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Bench for fifo_drain_ctrl: a behavioural FIFO with a frozen post-pop view, a
// timing-rule reference model compared every cycle, and directed plus random traffic.
module tb_fifo_drain_ctrl;
    localparam int DW = 8;
    localparam int S  = 3;
    localparam int CW = 4;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          busy;
    logic [CW-1:0] pop_count;
    logic [DW-1:0] wdata = 8'h00;

    fifo_drain_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    fifo_drain_ctrl #(.DATA_WIDTH(DW), .SETTLE_CYCLES(S), .COUNT_WIDTH(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .bus       (bus),
        .busy      (busy),
        .pop_count (pop_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural FIFO: after a pop, empty/head stay frozen for three edges.
    logic [DW-1:0] fq[$];
    int            stale = 0;
    always @(posedge clk) begin
        bit popped;
        popped = 1'b0;
        if (reset) begin
            fq.delete();
            stale = 0;
            bus.fifo_empty <= 1'b1;
            bus.fifo_data  <= 8'h00;
        end else begin
            if (bus.fifo_write === 1'b1) begin
                fq.push_back(wdata);
            end else if (bus.fifo_read === 1'b1) begin
                check("fifo_underflow", (fq.size() != 0), 1);
                if (fq.size() != 0) void'(fq.pop_front());
                popped = 1'b1;
            end
            if (popped) stale = 2;
            else if (stale > 0) stale--;
            else begin
                bus.fifo_empty <= (fq.size() == 0);
                bus.fifo_data  <= (fq.size() != 0) ? fq[0] : 8'h00;
            end
        end
    end

    // Reference model: pops in arrival order, one every S+2 cycles at best,
    // retried while a write collides, and a slot that load/flush/handshake rules update.
    logic [DW-1:0] sb[$];
    logic [DW-1:0] got[$];
    logic [DW-1:0] exp_q[$];
    bit            m_pend   = 1'b0;
    bit            m_valid  = 1'b0;
    logic [DW-1:0] m_data   = 8'h00;
    int            m_cnt    = 0;
    int            cyc      = 0;
    int            last_pop = -1000;
    int            last_rd  = -1000;

    always @(negedge clk) begin
        bit            exp_read;
        bit            exp_busy;
        bit            nv;
        logic [DW-1:0] d;
        cyc++;
        exp_read = m_pend && !bus.fifo_write && !reset;
        exp_busy = m_pend || (cyc <= last_pop + S) || m_valid;
        check("fifo_read", bus.fifo_read, exp_read);
        check("out_valid", bus.out_valid, m_valid);
        if (m_valid) check("out_data", bus.out_data, m_data);
        check("busy", busy, exp_busy);
        check("pop_count", pop_count, m_cnt % (1 << CW));
        if (bus.fifo_read === 1'b1) begin
            check("pop_spacing", ((cyc - last_rd) >= S + 2), 1);
            last_rd = cyc;
        end
        if (bus.out_valid === 1'b1 && bus.out_ready && !reset) got.push_back(bus.out_data);
        if (reset) begin
            m_pend   = 1'b0;
            m_valid  = 1'b0;
            m_data   = 8'h00;
            m_cnt    = 0;
            last_pop = -1000;
            last_rd  = -1000;
            sb.delete();
        end else begin
            nv = m_valid;
            if (exp_read) begin
                m_cnt++;
                d = (sb.size() != 0) ? sb.pop_front() : 8'h00;
                nv = !flush;
                if (!flush) m_data = d;
                last_pop = cyc;
                m_pend   = 1'b0;
            end else begin
                if (flush || (m_valid && bus.out_ready)) nv = 1'b0;
                if (!m_pend && (cyc > last_pop + S) && !bus.fifo_empty &&
                    (!m_valid || bus.out_ready || flush)) m_pend = 1'b1;
            end
            m_valid = nv;
            if (bus.fifo_write) sb.push_back(wdata);
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        got.delete();
        exp_q.delete();
    endtask

    task automatic drive_write(input logic [DW-1:0] b);
        bus.fifo_write = 1'b1;
        wdata          = b;
        exp_q.push_back(b);
    endtask

    task automatic push(input logic [DW-1:0] b);
        drive_write(b);
        @(posedge clk);
        #1;
        bus.fifo_write = 1'b0;
    endtask

    task automatic drain(input int lim);
        int n;
        n = 0;
        bus.fifo_write = 1'b0;
        bus.out_ready  = 1'b1;
        forever begin
            @(negedge clk);
            if (!busy && bus.fifo_empty) break;
            n++;
            if (n > lim) begin
                check("drain_timeout", n, lim);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_stream(input string name);
        check({name, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) check(name, got[i], exp_q[i]);
    endtask

    initial begin
        int n;
        bus.fifo_write = 1'b0;
        bus.out_ready  = 1'b0;
        do_reset();
        @(negedge clk);
        check("rst_valid", bus.out_valid, 0);
        check("rst_count", pop_count, 0);
        @(posedge clk);
        #1;

        // Single byte latency
        bus.out_ready = 1'b1;
        push(8'hA5);
        @(negedge clk);
        check("t1_empty_low", bus.fifo_empty, 0);
        check("t1_no_read_yet", bus.fifo_read, 0);
        @(negedge clk);
        check("t1_read_pulse", bus.fifo_read, 1);
        @(negedge clk);
        check("t1_valid", bus.out_valid, 1);
        check("t1_data", bus.out_data, 8'hA5);
        @(negedge clk);
        check("t1_valid_drop", bus.out_valid, 0);
        check("t1_count", pop_count, 1);
        drain(50);

        // Burst under backpressure
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(8'(i));
        repeat (20) @(posedge clk);
        #1;
        drain(300);
        check_stream("t2_order");
        check("t2_count", pop_count, 8);

        // Write/read collision, then a random 16-byte stream
        do_reset();
        bus.out_ready = 1'b1;
        push(8'h11);
        @(posedge clk);
        #1;
        drive_write(8'h22);
        @(negedge clk);
        check("t3_stall1", bus.fifo_read, 0);
        @(posedge clk);
        #1;
        drive_write(8'h33);
        @(negedge clk);
        check("t3_stall2", bus.fifo_read, 0);
        @(posedge clk);
        #1;
        bus.fifo_write = 1'b0;
        @(negedge clk);
        check("t3_pop", bus.fifo_read, 1);
        @(posedge clk);
        #1;
        n = 0;
        while (n < 13) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                drive_write(8'($urandom_range(0, 255)));
                n++;
            end else begin
                bus.fifo_write = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        drain(500);
        check_stream("t3_stream");

        // Flush discards everything popped while high
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(8'(8'h40 + i));
        flush = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        @(negedge clk);
        check("t4_valid", bus.out_valid, 0);
        check("t4_empty", bus.fifo_empty, 1);
        check("t4_count", pop_count, 5);
        @(posedge clk);
        #1;
        flush = 1'b0;
        got.delete();
        exp_q.delete();
        bus.out_ready = 1'b1;
        push(8'h3C);
        drain(100);
        check_stream("t4_after");

        // Reset while cooling down with a full slot
        do_reset();
        bus.out_ready = 1'b0;
        push(8'h77);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t5_loaded", bus.out_valid, 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("t5_valid", bus.out_valid, 0);
        check("t5_data", bus.out_data, 0);
        check("t5_count", pop_count, 0);
        check("t5_busy", busy, 0);
        check("t5_read", bus.fifo_read, 0);
        @(posedge clk);
        #1;
        got.delete();
        exp_q.delete();
        bus.out_ready = 1'b1;
        push(8'h5A);
        drain(100);
        check_stream("t5_resume");

        // Counter wrap with a 4-bit pop counter
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            push(8'(i * 7 + 3));
            repeat ($urandom_range(0, 6)) @(posedge clk);
            #1;
        end
        drain(300);
        check("t6_wrap", pop_count, 1);
        check_stream("t6_stream");

        // Random traffic with flush and backpressure
        do_reset();
        repeat (3000) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            flush         = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 5) == 0) drive_write(8'($urandom_range(0, 255)));
            else bus.fifo_write = 1'b0;
            @(posedge clk);
            #1;
        end
        flush = 1'b0;
        drain(4000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
